// File: rtl/vend_ctrl_param.sv
// Parametrised single-product vending controller: credit in 5 rs units,
// stock tracking, cancel/refund and multi-cycle change return.
module vend_ctrl_param #(
   parameter int PRICE_U    = 3,
   parameter int MAX_U      = 12,
   parameter int CREDIT_W   = 5,
   parameter int STOCK_INIT = 8,
   parameter int STOCK_W    = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [1:0]          in,
   input  logic                cancel,
   input  logic                restock,
   output logic                out,
   output logic [1:0]          change,
   output logic [1:0]          coin_rej,
   output logic [CREDIT_W-1:0] credit,
   output logic [STOCK_W-1:0]  stock,
   output logic                sold_out,
   output logic                busy
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCUM  = 2'd1,
      VEND   = 2'd2,
      CHANGE = 2'd3
   } state_t;

   localparam logic [CREDIT_W-1:0] PRICE  = CREDIT_W'(PRICE_U);
   localparam logic [CREDIT_W-1:0] MAX    = CREDIT_W'(MAX_U);
   localparam logic [STOCK_W-1:0]  S_INIT = STOCK_W'(STOCK_INIT);

   state_t state;

   function automatic logic [CREDIT_W-1:0] coin_val(input logic [1:0] c);
      case (c)
         2'b01:   coin_val = CREDIT_W'(1);
         2'b10:   coin_val = CREDIT_W'(2);
         2'b11:   coin_val = CREDIT_W'(4);
         default: coin_val = CREDIT_W'(0);
      endcase
   endfunction

   logic [CREDIT_W-1:0] sum;
   logic                accept;

   // CREDIT_W is sized to hold MAX_U+4, so the sum never overflows before the cap test
   assign sum    = credit + coin_val(in);
   assign accept = (in != 2'b00) && (stock != '0) && !cancel && (sum <= MAX);

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         out      <= 1'b0;
         change   <= 2'b00;
         coin_rej <= 2'b00;
         credit   <= '0;
         stock    <= S_INIT;
         sold_out <= (S_INIT == '0);
         busy     <= 1'b0;
      end else begin
         out      <= 1'b0;
         change   <= 2'b00;
         coin_rej <= 2'b00;
         case (state)
            IDLE, ACCUM: begin
               if (restock && state == IDLE) begin
                  stock    <= S_INIT;
                  sold_out <= (S_INIT == '0);
               end
               // cancel beats a simultaneous coin; the coin is bounced back
               if (state == ACCUM && cancel) begin
                  coin_rej <= in;
                  state    <= CHANGE;
                  busy     <= 1'b1;
               end else if (accept) begin
                  credit <= sum;
                  if (sum >= PRICE) begin
                     state <= VEND;
                     out   <= 1'b1;
                     busy  <= 1'b1;
                  end else begin
                     state <= ACCUM;
                  end
               end else begin
                  coin_rej <= in;
               end
            end
            VEND: begin
               coin_rej <= in;
               credit   <= credit - PRICE;
               stock    <= stock - STOCK_W'(1);
               sold_out <= (stock == STOCK_W'(1));
               if (credit == PRICE) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end else begin
                  state <= CHANGE;
               end
            end
            CHANGE: begin
               coin_rej <= in;
               // largest coin first; an extra edge at zero credit clears change
               if (credit == '0) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end else if (credit >= CREDIT_W'(2)) begin
                  change <= 2'b10;
                  credit <= credit - CREDIT_W'(2);
               end else begin
                  change <= 2'b01;
                  credit <= credit - CREDIT_W'(1);
               end
            end
            default: begin
               state  <= IDLE;
               credit <= '0;
               busy   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_vend_ctrl_param.sv
// Directed self-checking bench for vend_ctrl_param: default instance plus a
// PRICE_U=12 instance for the credit-cap boundary.
module tb_vend_ctrl_param;

   logic       clk = 1'b0;
   logic       rst, cancel, restock;
   logic [1:0] in;
   logic       out, sold_out, busy;
   logic [1:0] change, coin_rej;
   logic [4:0] credit;
   logic [3:0] stock;

   logic       rst_b, cancel_b, restock_b;
   logic [1:0] in_b;
   logic       out_b, sold_out_b, busy_b;
   logic [1:0] change_b, coin_rej_b;
   logic [4:0] credit_b;
   logic [3:0] stock_b;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   vend_ctrl_param dut (
      .clk(clk), .rst(rst), .in(in), .cancel(cancel), .restock(restock),
      .out(out), .change(change), .coin_rej(coin_rej), .credit(credit),
      .stock(stock), .sold_out(sold_out), .busy(busy)
   );

   vend_ctrl_param #(.PRICE_U(12), .MAX_U(12)) dut_b (
      .clk(clk), .rst(rst_b), .in(in_b), .cancel(cancel_b), .restock(restock_b),
      .out(out_b), .change(change_b), .coin_rej(coin_rej_b), .credit(credit_b),
      .stock(stock_b), .sold_out(sold_out_b), .busy(busy_b)
   );

   task automatic cyc(input logic [1:0] c, input logic cn, input logic rs);
      in = c; cancel = cn; restock = rs;
      @(posedge clk); #1;
      in = 2'b00; cancel = 1'b0; restock = 1'b0;
   endtask

   task automatic cyc_b(input logic [1:0] c);
      in_b = c;
      @(posedge clk); #1;
      in_b = 2'b00;
   endtask

   task automatic test_reset;
      rst = 1'b1; rst_b = 1'b1;
      cyc(2'b11, 1'b0, 1'b0);
      cyc(2'b00, 1'b0, 1'b0);
      rst = 1'b0; rst_b = 1'b0;
      n_cmp++; if (credit !== 5'd0) begin n_err++; $display("FAIL reset_credit got %0d exp 0", credit); end
      n_cmp++; if (stock !== 4'd8) begin n_err++; $display("FAIL reset_stock got %0d exp 8", stock); end
      n_cmp++; if ({out, change, coin_rej, sold_out, busy} !== 7'd0) begin n_err++; $display("FAIL reset_flags got %b exp 0000000", {out, change, coin_rej, sold_out, busy}); end
   endtask

   task automatic test_exact_price;
      cyc(2'b01, 1'b0, 1'b0);
      n_cmp++; if (credit !== 5'd1) begin n_err++; $display("FAIL exact_credit1 got %0d exp 1", credit); end
      cyc(2'b01, 1'b0, 1'b0);
      n_cmp++; if (credit !== 5'd2) begin n_err++; $display("FAIL exact_credit2 got %0d exp 2", credit); end
      cyc(2'b01, 1'b0, 1'b0);
      n_cmp++; if ({credit, out, busy} !== {5'd3, 1'b1, 1'b1}) begin n_err++; $display("FAIL exact_vend got credit=%0d out=%b busy=%b exp 3 1 1", credit, out, busy); end
      cyc(2'b00, 1'b0, 1'b0);
      n_cmp++; if ({credit, stock, out, change, busy} !== {5'd0, 4'd7, 1'b0, 2'b00, 1'b0}) begin n_err++; $display("FAIL exact_done got credit=%0d stock=%0d out=%b change=%b busy=%b exp 0 7 0 00 0", credit, stock, out, change, busy); end
   endtask

   task automatic test_change_one;
      cyc(2'b11, 1'b0, 1'b0);
      n_cmp++; if ({credit, out} !== {5'd4, 1'b1}) begin n_err++; $display("FAIL c1_vend got credit=%0d out=%b exp 4 1", credit, out); end
      cyc(2'b00, 1'b0, 1'b0);
      n_cmp++; if ({credit, stock, out, busy} !== {5'd1, 4'd6, 1'b0, 1'b1}) begin n_err++; $display("FAIL c1_post got credit=%0d stock=%0d out=%b busy=%b exp 1 6 0 1", credit, stock, out, busy); end
      cyc(2'b00, 1'b0, 1'b0);
      n_cmp++; if ({change, credit} !== {2'b01, 5'd0}) begin n_err++; $display("FAIL c1_coin got change=%b credit=%0d exp 01 0", change, credit); end
      cyc(2'b00, 1'b0, 1'b0);
      n_cmp++; if ({change, busy} !== {2'b00, 1'b0}) begin n_err++; $display("FAIL c1_idle got change=%b busy=%b exp 00 0", change, busy); end
   endtask

   task automatic test_change_two;
      cyc(2'b10, 1'b0, 1'b0);
      n_cmp++; if ({credit, out} !== {5'd2, 1'b0}) begin n_err++; $display("FAIL c2_acc got credit=%0d out=%b exp 2 0", credit, out); end
      cyc(2'b11, 1'b0, 1'b0);
      n_cmp++; if ({credit, out} !== {5'd6, 1'b1}) begin n_err++; $display("FAIL c2_vend got credit=%0d out=%b exp 6 1", credit, out); end
      cyc(2'b00, 1'b0, 1'b0);
      n_cmp++; if ({credit, stock} !== {5'd3, 4'd5}) begin n_err++; $display("FAIL c2_post got credit=%0d stock=%0d exp 3 5", credit, stock); end
      cyc(2'b00, 1'b0, 1'b0);
      n_cmp++; if ({change, credit} !== {2'b10, 5'd1}) begin n_err++; $display("FAIL c2_ten got change=%b credit=%0d exp 10 1", change, credit); end
      cyc(2'b00, 1'b0, 1'b0);
      n_cmp++; if ({change, credit} !== {2'b01, 5'd0}) begin n_err++; $display("FAIL c2_five got change=%b credit=%0d exp 01 0", change, credit); end
      cyc(2'b00, 1'b0, 1'b0);
      n_cmp++; if ({change, busy} !== {2'b00, 1'b0}) begin n_err++; $display("FAIL c2_idle got change=%b busy=%b exp 00 0", change, busy); end
   endtask

   task automatic test_cancel;
      cyc(2'b10, 1'b0, 1'b0);
      n_cmp++; if (credit !== 5'd2) begin n_err++; $display("FAIL can_acc got %0d exp 2", credit); end
      cyc(2'b01, 1'b1, 1'b0);
      n_cmp++; if ({coin_rej, credit, out, busy} !== {2'b01, 5'd2, 1'b0, 1'b1}) begin n_err++; $display("FAIL can_rej got rej=%b credit=%0d out=%b busy=%b exp 01 2 0 1", coin_rej, credit, out, busy); end
      cyc(2'b00, 1'b0, 1'b0);
      n_cmp++; if ({change, credit, out, coin_rej} !== {2'b10, 5'd0, 1'b0, 2'b00}) begin n_err++; $display("FAIL can_ref got change=%b credit=%0d out=%b rej=%b exp 10 0 0 00", change, credit, out, coin_rej); end
      cyc(2'b00, 1'b0, 1'b0);
      n_cmp++; if ({change, busy, out, stock} !== {2'b00, 1'b0, 1'b0, 4'd5}) begin n_err++; $display("FAIL can_idle got change=%b busy=%b out=%b stock=%0d exp 00 0 0 5", change, busy, out, stock); end
   endtask

   task automatic test_sold_out_restock;
      for (int i = 0; i < 5; i++) begin
         cyc(2'b10, 1'b0, 1'b0);
         cyc(2'b01, 1'b0, 1'b0);
         cyc(2'b00, 1'b0, 1'b0);
      end
      n_cmp++; if ({stock, sold_out, credit} !== {4'd0, 1'b1, 5'd0}) begin n_err++; $display("FAIL so_empty got stock=%0d sold_out=%b credit=%0d exp 0 1 0", stock, sold_out, credit); end
      cyc(2'b10, 1'b0, 1'b0);
      n_cmp++; if ({coin_rej, credit} !== {2'b10, 5'd0}) begin n_err++; $display("FAIL so_reject got rej=%b credit=%0d exp 10 0", coin_rej, credit); end
      cyc(2'b00, 1'b0, 1'b1);
      n_cmp++; if ({stock, sold_out, coin_rej} !== {4'd8, 1'b0, 2'b00}) begin n_err++; $display("FAIL so_restock got stock=%0d sold_out=%b rej=%b exp 8 0 00", stock, sold_out, coin_rej); end
   endtask

   task automatic test_reset_mid_change;
      cyc(2'b10, 1'b0, 1'b0);
      cyc(2'b11, 1'b0, 1'b0);
      cyc(2'b00, 1'b0, 1'b0);
      n_cmp++; if ({credit, stock} !== {5'd3, 4'd7}) begin n_err++; $display("FAIL rm_post got credit=%0d stock=%0d exp 3 7", credit, stock); end
      cyc(2'b00, 1'b0, 1'b0);
      n_cmp++; if ({change, credit} !== {2'b10, 5'd1}) begin n_err++; $display("FAIL rm_ten got change=%b credit=%0d exp 10 1", change, credit); end
      rst = 1'b1;
      cyc(2'b00, 1'b0, 1'b0);
      rst = 1'b0;
      n_cmp++; if ({change, credit, stock, busy} !== {2'b00, 5'd0, 4'd8, 1'b0}) begin n_err++; $display("FAIL rm_reset got change=%b credit=%0d stock=%0d busy=%b exp 00 0 8 0", change, credit, stock, busy); end
      cyc(2'b01, 1'b0, 1'b0);
      n_cmp++; if ({credit, change} !== {5'd1, 2'b00}) begin n_err++; $display("FAIL rm_resume got credit=%0d change=%b exp 1 00", credit, change); end
   endtask

   task automatic test_credit_cap;
      cyc_b(2'b11);
      cyc_b(2'b11);
      cyc_b(2'b10);
      n_cmp++; if ({credit_b, out_b} !== {5'd10, 1'b0}) begin n_err++; $display("FAIL cap_acc got credit=%0d out=%b exp 10 0", credit_b, out_b); end
      cyc_b(2'b11);
      n_cmp++; if ({credit_b, coin_rej_b, out_b} !== {5'd10, 2'b11, 1'b0}) begin n_err++; $display("FAIL cap_rej got credit=%0d rej=%b out=%b exp 10 11 0", credit_b, coin_rej_b, out_b); end
      cyc_b(2'b10);
      n_cmp++; if ({credit_b, out_b, coin_rej_b} !== {5'd12, 1'b1, 2'b00}) begin n_err++; $display("FAIL cap_vend got credit=%0d out=%b rej=%b exp 12 1 00", credit_b, out_b, coin_rej_b); end
      cyc_b(2'b00);
      n_cmp++; if ({credit_b, stock_b, busy_b} !== {5'd0, 4'd7, 1'b0}) begin n_err++; $display("FAIL cap_done got credit=%0d stock=%0d busy=%b exp 0 7 0", credit_b, stock_b, busy_b); end
   endtask

   initial begin
      in = 2'b00; cancel = 1'b0; restock = 1'b0; rst = 1'b1;
      in_b = 2'b00; cancel_b = 1'b0; restock_b = 1'b0; rst_b = 1'b1;
      test_reset();
      test_exact_price();
      test_change_one();
      test_change_two();
      test_cancel();
      test_sold_out_restock();
      test_reset_mid_change();
      test_credit_cap();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
